// File: rtl/stack_seq_pkg.sv
// Shared types and elaboration-time helpers for the stack access sequencer.
// Imported by the sequencer interface and the sequencer itself.
package stack_seq_pkg;

    typedef enum logic [1:0] {
        OP_NONE = 2'b00,
        OP_PUSH = 2'b10,
        OP_POP  = 2'b11
    } stack_op_e;

    typedef enum logic {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } seq_state_e;

    function automatic bit params_ok(input int pc_words, input int flag_words);
        return (pc_words >= 32'sd1) && (pc_words <= 32'sd4) &&
               (flag_words >= 32'sd0) && (flag_words <= 32'sd2);
    endfunction

    function automatic int cnt_width(input int pc_words, input int flag_words);
        return $clog2(pc_words + flag_words + 32'sd1);
    endfunction

endpackage

// File: rtl/stack_access_sequencer_if.sv
// Request/control bundle between the memory-stage pipeline (master)
// and the stack access sequencer (slave).
interface stack_access_sequencer_if
    import stack_seq_pkg::*;
#(
    parameter int PC_WORDS   = 2,
    parameter int FLAG_WORDS = 1
);
    localparam int CNT_W = cnt_width(PC_WORDS, FLAG_WORDS);

    logic             stack_pc;
    logic             stack_flags;
    logic             mem_read;
    logic             mem_write;
    logic             abort;
    logic             stall;
    logic             busy;
    stack_op_e        stack_op;
    logic [CNT_W-1:0] word_idx;
    logic             is_flags;
    logic             done;

    modport master (
        output stack_pc, stack_flags, mem_read, mem_write, abort,
        input  stall, busy, stack_op, word_idx, is_flags, done
    );

    modport slave (
        input  stack_pc, stack_flags, mem_read, mem_write, abort,
        output stall, busy, stack_op, word_idx, is_flags, done
    );
endinterface

// File: rtl/stack_access_sequencer.sv
// Expands one PC/flags push or pop into single-word memory operations.
// Define STACK_SEQ_BACK2BACK_EN to accept a new request in the done cycle.
module stack_access_sequencer
    import stack_seq_pkg::*;
#(
    parameter int PC_WORDS   = 2,
    parameter int FLAG_WORDS = 1
) (
    input logic                     clk,
    input logic                     rst_n,
    stack_access_sequencer_if.slave bus
);
    localparam int               CNT_W    = cnt_width(PC_WORDS, FLAG_WORDS);
    localparam bit               FLAGS_EN = (FLAG_WORDS > 0);
    localparam logic [CNT_W-1:0] ONE      = CNT_W'(1);
    localparam logic [CNT_W-1:0] PC_LAST  = CNT_W'(PC_WORDS - 1);
    localparam logic [CNT_W-1:0] FL_LAST  = FLAGS_EN ? CNT_W'(FLAG_WORDS - 1) : '0;
    localparam logic [CNT_W-1:0] LEN_PC   = CNT_W'(PC_WORDS);
    localparam logic [CNT_W-1:0] LEN_ALL  = CNT_W'(PC_WORDS + FLAG_WORDS);
`ifdef STACK_SEQ_BACK2BACK_EN
    localparam bit               B2B_EN   = 1'b1;
`else
    localparam bit               B2B_EN   = 1'b0;
`endif

    if (!params_ok(PC_WORDS, FLAG_WORDS)) begin : g_param_err
        $error("stack_access_sequencer: PC_WORDS must be 1..4, FLAG_WORDS 0..2");
    end

    seq_state_e       state_q, state_d;
    stack_op_e        op_q, op_d;
    logic             is_flags_q, is_flags_d;
    logic [CNT_W-1:0] idx_q, idx_d;
    logic [CNT_W-1:0] rem_q, rem_d;
    logic             stall_q, stall_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             take_req_s;
    logic             with_flags_s;

    // State and registered outputs, synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            op_q       <= OP_NONE;
            is_flags_q <= 1'b0;
            idx_q      <= '0;
            rem_q      <= '0;
            stall_q    <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            op_q       <= op_d;
            is_flags_q <= is_flags_d;
            idx_q      <= idx_d;
            rem_q      <= rem_d;
            stall_q    <= stall_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    // Next-state: accept, advance one word, or fall back to idle.
    always_comb begin
        state_d      = state_q;
        op_d         = op_q;
        is_flags_d   = is_flags_q;
        idx_d        = idx_q;
        rem_d        = rem_q;
        take_req_s   = 1'b0;
        with_flags_s = bus.stack_flags && FLAGS_EN;

        case (state_q)
            IDLE:    take_req_s = bus.stack_pc;
            ACTIVE: begin
                if (rem_q == ONE) begin
                    take_req_s = B2B_EN && bus.stack_pc;
                end else begin
                    take_req_s = 1'b0;
                end
            end
            default: take_req_s = 1'b0;
        endcase

        if (bus.abort) begin
            state_d    = IDLE;
            op_d       = OP_NONE;
            is_flags_d = 1'b0;
            idx_d      = '0;
            rem_d      = '0;
        end else if (take_req_s) begin
            state_d = ACTIVE;
            rem_d   = with_flags_s ? LEN_ALL : LEN_PC;
            if (bus.mem_read) begin
                // Pop unwinds LIFO: flags came last, so they come back first.
                op_d       = OP_POP;
                is_flags_d = with_flags_s;
                idx_d      = '0;
            end else begin
                op_d       = bus.mem_write ? OP_PUSH : OP_NONE;
                is_flags_d = 1'b0;
                idx_d      = PC_LAST;
            end
        end else if ((state_q == ACTIVE) && (rem_q != ONE)) begin
            rem_d = rem_q - ONE;
            if (op_q == OP_POP) begin
                if (is_flags_q && (idx_q == FL_LAST)) begin
                    is_flags_d = 1'b0;
                    idx_d      = '0;
                end else begin
                    idx_d = idx_q + ONE;
                end
            end else begin
                if (!is_flags_q && (idx_q == '0)) begin
                    is_flags_d = 1'b1;
                    idx_d      = FL_LAST;
                end else begin
                    idx_d = idx_q - ONE;
                end
            end
        end else begin
            state_d    = IDLE;
            op_d       = OP_NONE;
            is_flags_d = 1'b0;
            idx_d      = '0;
            rem_d      = '0;
        end

        busy_d  = (state_d == ACTIVE);
        stall_d = busy_d && (rem_d != ONE);
        done_d  = busy_d && (rem_d == ONE);
    end

    assign bus.stall    = stall_q;
    assign bus.busy     = busy_q;
    assign bus.stack_op = op_q;
    assign bus.word_idx = idx_q;
    assign bus.is_flags = is_flags_q;
    assign bus.done     = done_q;

endmodule

// File: tb/tb_stack_access_sequencer.sv
// Self-checking bench: two sequencer configurations driven by one stimulus stream,
// each checked every cycle against a queue-of-words reference model.
module tb_stack_access_sequencer;
    import stack_seq_pkg::*;

    localparam int PW0 = 2, FW0 = 1;
    localparam int PW1 = 4, FW1 = 2;

    typedef struct packed {
        logic [1:0] op;
        logic       fl;
        logic [7:0] idx;
        logic       last;
    } word_t;

    logic clk = 1'b0;
    logic rst_n;
    logic pc_s, fl_s, rd_s, wr_s, ab_s;
    int   n_chk = 0;
    int   n_fail = 0;
    bit   chk_en = 1'b0;
    word_t mq[2][$];

    always #5 clk = ~clk;

    stack_access_sequencer_if #(.PC_WORDS(PW0), .FLAG_WORDS(FW0)) if0 ();
    stack_access_sequencer_if #(.PC_WORDS(PW1), .FLAG_WORDS(FW1)) if1 ();

    assign if0.stack_pc = pc_s;  assign if1.stack_pc = pc_s;
    assign if0.stack_flags = fl_s; assign if1.stack_flags = fl_s;
    assign if0.mem_read = rd_s;  assign if1.mem_read = rd_s;
    assign if0.mem_write = wr_s; assign if1.mem_write = wr_s;
    assign if0.abort = ab_s;     assign if1.abort = ab_s;

    stack_access_sequencer #(.PC_WORDS(PW0), .FLAG_WORDS(FW0)) dut0 (
        .clk(clk), .rst_n(rst_n), .bus(if0.slave));
    stack_access_sequencer #(.PC_WORDS(PW1), .FLAG_WORDS(FW1)) dut1 (
        .clk(clk), .rst_n(rst_n), .bus(if1.slave));

    function automatic word_t mk(input logic [1:0] op, input logic fl, input int idx);
        word_t w;
        w.op = op; w.fl = fl; w.idx = 8'(idx); w.last = 1'b0;
        return w;
    endfunction

    // Reference model: the queue holds every word still to be issued; its front is this cycle's word.
    task automatic model_step(input int k, input int pw, input int fw);
        bit was_idle, was_last, b2b, fl;
        logic [1:0] op;
        word_t w;
        if (!rst_n || ab_s) begin
            mq[k].delete();
            return;
        end
        was_idle = (mq[k].size() == 0);
        was_last = (mq[k].size() == 1);
`ifdef STACK_SEQ_BACK2BACK_EN
        b2b = 1'b1;
`else
        b2b = 1'b0;
`endif
        if (!was_idle) void'(mq[k].pop_front());
        if (pc_s && (was_idle || (b2b && was_last))) begin
            fl = fl_s && (fw > 0);
            if (rd_s) begin
                op = 2'b11;
                if (fl) for (int i = 0; i < fw; i++) mq[k].push_back(mk(op, 1'b1, i));
                for (int i = 0; i < pw; i++) mq[k].push_back(mk(op, 1'b0, i));
            end else begin
                op = wr_s ? 2'b10 : 2'b00;
                for (int i = pw - 1; i >= 0; i--) mq[k].push_back(mk(op, 1'b0, i));
                if (fl) for (int i = fw - 1; i >= 0; i--) mq[k].push_back(mk(op, 1'b1, i));
            end
            w = mq[k].pop_back();
            w.last = 1'b1;
            mq[k].push_back(w);
        end
    endtask

    always @(posedge clk) begin
        model_step(0, PW0, FW0);
        model_step(1, PW1, FW1);
    end

    task automatic get_out(input int k, output logic bsy, output logic stl, output logic dn,
                           output logic [1:0] op, output logic fl, output int idx);
        if (k == 0) begin
            bsy = if0.busy; stl = if0.stall; dn = if0.done;
            op = if0.stack_op; fl = if0.is_flags; idx = int'(if0.word_idx);
        end else begin
            bsy = if1.busy; stl = if1.stall; dn = if1.done;
            op = if1.stack_op; fl = if1.is_flags; idx = int'(if1.word_idx);
        end
    endtask

    task automatic cmp_model(input int k);
        logic bsy, stl, dn, fl, ebsy, estl, edn;
        logic [1:0] op;
        int idx;
        word_t e;
        bit bad;
        get_out(k, bsy, stl, dn, op, fl, idx);
        ebsy = (mq[k].size() != 0);
        e = ebsy ? mq[k][0] : mk(2'b00, 1'b0, 0);
        estl = ebsy && !e.last;
        edn = ebsy && e.last;
        bad = (bsy !== ebsy) || (stl !== estl) || (dn !== edn) || (op !== e.op);
        if (!ebsy || e.op != 2'b00) bad = bad || (fl !== e.fl) || (idx != int'(e.idx));
        n_chk++;
        if (bad) begin
            n_fail++;
            $display("FAIL model_dut%0d t=%0t: got busy=%b stall=%b done=%b op=%b fl=%b idx=%0d, need busy=%b stall=%b done=%b op=%b fl=%b idx=%0d",
                     k, $time, bsy, stl, dn, op, fl, idx, ebsy, estl, edn, e.op, e.fl, e.idx);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            cmp_model(0);
            cmp_model(1);
        end
    end

    task automatic chk_lit(input string name, input int k, input logic ebsy, input logic estl,
                           input logic edn, input logic [1:0] eop, input logic efl, input int eidx);
        logic bsy, stl, dn, fl;
        logic [1:0] op;
        int idx;
        get_out(k, bsy, stl, dn, op, fl, idx);
        n_chk++;
        if (bsy !== ebsy || stl !== estl || dn !== edn || op !== eop || fl !== efl || idx != eidx) begin
            n_fail++;
            $display("FAIL %s: got busy=%b stall=%b done=%b op=%b fl=%b idx=%0d, need busy=%b stall=%b done=%b op=%b fl=%b idx=%0d",
                     name, bsy, stl, dn, op, fl, idx, ebsy, estl, edn, eop, efl, eidx);
        end
    endtask

    task automatic tick(input logic pc, input logic fl, input logic rd, input logic wr, input logic ab);
        pc_s = pc; fl_s = fl; rd_s = rd; wr_s = wr; ab_s = ab;
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((mq[0].size() != 0 || mq[1].size() != 0) && n < 20) begin
            tick(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
            n++;
        end
        tick(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        n_chk++;
        if (n >= 20) begin
            n_fail++;
            $display("FAIL wait_idle: got still busy after %0d cycles, need idle", n);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        tick(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        tick(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk_en = 1'b1;
        chk_lit("reset_dut0", 0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 0);
        chk_lit("reset_dut1", 1, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 0);
        rst_n = 1'b1;
        tick(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

        // 3-word push with flags
        tick(1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
        chk_lit("push_c1", 0, 1'b1, 1'b1, 1'b0, 2'b10, 1'b0, 1);
        tick(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk_lit("push_c2", 0, 1'b1, 1'b1, 1'b0, 2'b10, 1'b0, 0);
        tick(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk_lit("push_c3", 0, 1'b1, 1'b0, 1'b1, 2'b10, 1'b1, 0);
        tick(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk_lit("push_end", 0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 0);
        wait_idle();

        // 2-word pop without flags
        tick(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        chk_lit("pop_c1", 0, 1'b1, 1'b1, 1'b0, 2'b11, 1'b0, 0);
        tick(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk_lit("pop_c2", 0, 1'b1, 1'b0, 1'b1, 2'b11, 1'b0, 1);
        wait_idle();

        // abort in cycle 2 of a push, with a competing request
        tick(1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
        tick(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        tick(1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
        chk_lit("abort_c3", 0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 0);
        tick(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk_lit("abort_noreq", 0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 0);
        wait_idle();

        // read wins over write; mid-sequence input changes are ignored
        tick(1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
        chk_lit("rw_c1", 0, 1'b1, 1'b1, 1'b0, 2'b11, 1'b0, 0);
        tick(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        chk_lit("rw_c2", 0, 1'b1, 1'b0, 1'b1, 2'b11, 1'b0, 1);
        wait_idle();

        // request during the done cycle
        tick(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        tick(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk_lit("b2b_done", 0, 1'b1, 1'b0, 1'b1, 2'b10, 1'b0, 0);
        tick(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
`ifdef STACK_SEQ_BACK2BACK_EN
        chk_lit("b2b_next", 0, 1'b1, 1'b1, 1'b0, 2'b11, 1'b0, 0);
`else
        chk_lit("b2b_drop", 0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 0);
`endif
        wait_idle();

        // reset mid-sequence on the 4-word configuration
        tick(1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
        chk_lit("pw4_c1", 1, 1'b1, 1'b1, 1'b0, 2'b10, 1'b0, 3);
        tick(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        rst_n = 1'b0;
        tick(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk_lit("rst_mid", 1, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 0);
        rst_n = 1'b1;

        // flags without a PC request
        tick(1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
        chk_lit("flags_only", 0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 0);
        wait_idle();

        for (int i = 0; i < 3000; i++) begin
            rst_n = ($urandom_range(0, 199) != 0);
            tick(($urandom_range(0, 2) == 0), $urandom_range(0, 1) == 1, ($urandom_range(0, 2) == 0),
                 $urandom_range(0, 1) == 1, ($urandom_range(0, 15) == 0));
        end
        rst_n = 1'b1;
        wait_idle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
